// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V main control: FETCH/DECODE/EXEC/MEM/WB sequencer with
// valid/ready fetch handshake and memory timeout. `CTRL_ITYPE_EN adds I-type ALU.
module multicycle_control #(
  parameter int ALUOP_WIDTH  = 2,
  parameter int OPCODE_WIDTH = 7,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  output logic                    Branch,
  output logic                    MemRead,
  output logic                    MemtoReg,
  output logic                    MemWrite,
  output logic                    ALUSrc,
  output logic                    RegWrite,
  output logic [ALUOP_WIDTH-1:0]  ALUOp,
  output logic                    illegal,
  output logic                    mem_timeout,
  output logic                    retire,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {C_R, C_LD, C_SD, C_BEQ, C_ITYPE, C_ILL} cls_t;

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t                  state_q;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [7:0]              cnt_q;
  cls_t                    cls;
  logic [1:0]              exec_aluop;
  logic                    exec_alusrc;
  logic                    timeout_hit;

  function automatic cls_t classify(input logic [OPCODE_WIDTH-1:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0000011: return C_LD;
      7'b0100011: return C_SD;
      7'b1100011: return C_BEQ;
`ifdef CTRL_ITYPE_EN
      7'b0010011: return C_ITYPE;
`endif
      default:    return C_ILL;
    endcase
  endfunction

  assign cls         = classify(op_q);
  assign timeout_hit = !mem_ready && (cnt_q == CNT_LAST);
  assign state       = state_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (instr_valid) begin
            op_q    <= opcode;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: state_q <= (cls == C_ILL) ? S_FETCH : S_EXEC;
        S_EXEC: begin
          cnt_q <= '0;
          case (cls)
            C_BEQ:       state_q <= S_FETCH;
            C_LD, C_SD:  state_q <= S_MEM;
            default:     state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          // A ready in the final allowed cycle wins over the timeout.
          if (mem_ready)        state_q <= (cls == C_LD) ? S_WB : S_FETCH;
          else if (timeout_hit) state_q <= S_FETCH;
          else                  cnt_q   <= cnt_q + 8'd1;
        end
        S_WB:    state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    exec_aluop  = 2'b00;
    exec_alusrc = 1'b0;
    case (cls)
      C_R:        exec_aluop = 2'b10;
      C_LD, C_SD: exec_alusrc = 1'b1;
      C_BEQ:      exec_aluop = 2'b01;
      C_ITYPE: begin
        exec_aluop  = 2'b11;
        exec_alusrc = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    instr_ready = 1'b0;
    Branch      = 1'b0;
    MemRead     = 1'b0;
    MemtoReg    = 1'b0;
    MemWrite    = 1'b0;
    ALUSrc      = 1'b0;
    RegWrite    = 1'b0;
    ALUOp       = '0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    retire      = 1'b0;
    case (state_q)
      S_FETCH:  instr_ready = rst_n;
      S_DECODE: illegal = (cls == C_ILL);
      S_EXEC: begin
        ALUOp  = ALUOP_WIDTH'(exec_aluop);
        ALUSrc = exec_alusrc;
        Branch = (cls == C_BEQ);
        retire = (cls == C_BEQ);
      end
      S_MEM: begin
        ALUSrc      = 1'b1;
        MemRead     = (cls == C_LD);
        MemWrite    = (cls == C_SD);
        retire      = (cls == C_SD) && mem_ready;
        mem_timeout = timeout_hit;
      end
      S_WB: begin
        ALUOp    = ALUOP_WIDTH'(exec_aluop);
        ALUSrc   = exec_alusrc;
        RegWrite = 1'b1;
        MemtoReg = (cls == C_LD);
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected cycle
// sequences built from the control rules, compared every cycle at negedge.
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam int T = 16;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, instr_ready, mem_ready;
  logic [6:0] opcode;
  logic       Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic [1:0] ALUOp;
  logic       illegal, mem_timeout, retire;
  logic [2:0] state;

  multicycle_control #(.ALUOP_WIDTH(2), .OPCODE_WIDTH(7), .MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .mem_ready(mem_ready), .Branch(Branch), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .ALUOp(ALUOp), .illegal(illegal), .mem_timeout(mem_timeout), .retire(retire),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic rdy, br, mr, m2r, mw, as, rw;
    logic [1:0] aop;
    logic ill, tmo, ret;
  } obs_t;

  typedef enum {K_R, K_LD, K_SD, K_BEQ, K_I, K_ILL} kind_t;

  obs_t  obs, exp_o;
  string exp_name = "";
  bit    exp_en = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  assign obs = {state, instr_ready, Branch, MemRead, MemtoReg, MemWrite, ALUSrc,
                RegWrite, ALUOp, illegal, mem_timeout, retire};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_en) check(exp_name, 32'(obs), 32'(exp_o));
  end

  function automatic kind_t kind_of(input logic [6:0] op);
    if (op == OP_R)   return K_R;
    if (op == OP_LD)  return K_LD;
    if (op == OP_SD)  return K_SD;
    if (op == OP_BEQ) return K_BEQ;
`ifdef CTRL_ITYPE_EN
    if (op == OP_I)   return K_I;
`endif
    return K_ILL;
  endfunction

  function automatic logic [1:0] aop_of(input kind_t k);
    case (k)
      K_R:     return 2'b10;
      K_BEQ:   return 2'b01;
      K_I:     return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic obs_t fetch_rec();
    obs_t e = '0;
    e.rdy = 1'b1;
    return e;
  endfunction

  // Drive one cycle's inputs just after the edge and publish what it must show.
  task automatic cyc(input obs_t e, input logic v, input logic [6:0] op,
                     input logic mr, input string nm);
    @(posedge clk);
    #1;
    instr_valid = v;
    opcode      = op;
    mem_ready   = mr;
    exp_o       = e;
    exp_name    = nm;
    exp_en      = 1'b1;
  endtask

  // One instruction: idle FETCH cycles, handshake, then the expected sequence.
  // stall = number of MEM cycles with mem_ready low before it rises.
  task automatic run(input logic [6:0] op, input int stall, input int idle, input string nm);
    kind_t k = kind_of(op);
    obs_t  e;
    int    m;
    bit    is_mem = (k == K_LD) || (k == K_SD);
    for (int i = 0; i < idle; i++) cyc(fetch_rec(), 1'b0, 7'($urandom), 1'($urandom), {nm, "/idle"});
    cyc(fetch_rec(), 1'b1, op, 1'($urandom), {nm, "/fetch"});

    e = '0; e.st = 3'd1; e.ill = (k == K_ILL);
    cyc(e, 1'($urandom), 7'($urandom), 1'($urandom), {nm, "/decode"});
    if (k == K_ILL) return;

    e = '0; e.st = 3'd2; e.aop = aop_of(k);
    e.as = is_mem || (k == K_I);
    e.br = (k == K_BEQ); e.ret = (k == K_BEQ);
    cyc(e, 1'($urandom), 7'($urandom), 1'($urandom), {nm, "/exec"});
    if (k == K_BEQ) return;

    if (is_mem) begin
      for (m = 0; m < T; m++) begin
        bit rd = (m >= stall);
        e = '0; e.st = 3'd3; e.as = 1'b1;
        e.mr = (k == K_LD); e.mw = (k == K_SD);
        e.ret = (k == K_SD) && rd;
        e.tmo = !rd && (m == T - 1);
        cyc(e, 1'($urandom), 7'($urandom), rd, $sformatf("%s/mem%0d", nm, m));
        if (rd) break;
      end
      if (k == K_SD || m == T) return;
    end

    e = '0; e.st = 3'd4; e.rw = 1'b1; e.ret = 1'b1;
    e.m2r = (k == K_LD); e.aop = aop_of(k); e.as = (k == K_LD) || (k == K_I);
    cyc(e, 1'($urandom), 7'($urandom), 1'($urandom), {nm, "/wb"});
  endtask

  // Count cycles from handshake until instr_ready returns, against a literal.
  task automatic lat_check(input logic [6:0] op, input logic mr, input int want, input string nm);
    int n = 0;
    @(posedge clk);
    #1;
    exp_en = 1'b0;
    instr_valid = 1'b1; opcode = op; mem_ready = mr;
    @(posedge clk);
    #1;
    instr_valid = 1'b0; opcode = 7'($urandom);
    forever begin
      @(negedge clk);
      if (instr_ready) break;
      n++;
      if (n > 60) break;
    end
    check({"latency_", nm}, 32'(n), 32'(want));
  endtask

  initial begin
    obs_t e;
    logic [6:0] ops [6];
    ops[0] = OP_R; ops[1] = OP_LD; ops[2] = OP_SD; ops[3] = OP_BEQ; ops[4] = OP_I; ops[5] = OP_BAD;
    instr_valid = 1'b0; opcode = '0; mem_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    exp_o = '0; exp_name = "in_reset"; exp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_o = fetch_rec(); exp_name = "after_reset";

    // Directed: one of each, including stalls and both timeout corner cases.
    run(OP_R,   0, 0, "r");
    run(OP_LD,  3, 0, "ld_stall3");
    run(OP_SD,  0, 1, "sd");
    run(OP_BEQ, 0, 0, "beq");
    run(OP_BAD, 0, 0, "illegal");
    run(OP_I,   0, 0, "itype");
    run(OP_LD,  T, 0, "ld_timeout");
    run(OP_LD,  T - 1, 0, "ld_ready_last");
    run(OP_SD,  T + 3, 2, "sd_timeout");

    // Asynchronous reset in the middle of an ld memory stall.
    e = fetch_rec();
    cyc(e, 1'b1, OP_LD, 1'b0, "rst/fetch");
    e = '0; e.st = 3'd1;
    cyc(e, 1'b0, 7'd0, 1'b0, "rst/decode");
    e = '0; e.st = 3'd2; e.as = 1'b1;
    cyc(e, 1'b0, 7'd0, 1'b0, "rst/exec");
    e = '0; e.st = 3'd3; e.as = 1'b1; e.mr = 1'b1;
    cyc(e, 1'b0, 7'd0, 1'b0, "rst/mem0");
    cyc(e, 1'b0, 7'd0, 1'b0, "rst/mem1");
    #2 rst_n = 1'b0;
    exp_o = '0; exp_name = "rst_mid_mem";
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    exp_o = fetch_rec(); exp_name = "rst_release";

    // Latencies pinned to hand-computed values.
    lat_check(OP_R,   1'b1, 3, "r");
    lat_check(OP_LD,  1'b1, 4, "ld");
    lat_check(OP_SD,  1'b1, 3, "sd");
    lat_check(OP_BEQ, 1'b1, 2, "beq");
    lat_check(OP_BAD, 1'b1, 1, "illegal");
    lat_check(OP_LD,  1'b0, 2 + T, "ld_timeout");
`ifdef CTRL_ITYPE_EN
    lat_check(OP_I,   1'b1, 3, "itype");
`else
    lat_check(OP_I,   1'b1, 1, "itype");
`endif

    // Randomized traffic: mixed opcodes, stalls, idle gaps, back-to-back fetch.
    for (int i = 0; i < 200; i++) begin
      logic [6:0] op;
      int stall, idle;
      op    = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
      stall = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 4);
      idle  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      run(op, stall, idle, $sformatf("rnd%0d", i));
    end

    @(posedge clk);
    #1 exp_en = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
